// File: rtl/cla_pkg.sv
// Shared types and sizes for the pipelined carry-lookahead subtractor.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_HALF  = CLA_WIDTH / 2;

  typedef logic [CLA_HALF-1:0] half_t;

  // Stage-1 payload: finished low half plus the raw high-half operands.
  typedef struct packed {
    half_t lo;
    logic  c_half;
    half_t a_hi;
    half_t nb_hi;
  } s1_t;

endpackage

// File: rtl/cla_adder_8bits.sv
// Half-width carry-lookahead adder; every carry is a flat sum of
// generate/propagate products, plus group propagate/generate outputs.
module cla_adder_8bits
  import cla_pkg::*;
(
  input  logic [CLA_HALF-1:0] in0,
  input  logic [CLA_HALF-1:0] in1,
  input  logic                carry_in,
  output logic [CLA_HALF-1:0] sum,
  output logic                carry_out,
  output logic                pg,
  output logic                gg
);

  logic [CLA_HALF-1:0] gen;
  logic [CLA_HALF-1:0] prop;
  logic [CLA_HALF:0]   carry;
  logic                gen_acc;
  logic                prop_acc;
  logic                group_gen;

  assign gen  = in0 & in1;
  assign prop = in0 ^ in1;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    carry     = '0;
    gen_acc   = 1'b0;
    prop_acc  = 1'b1;
    group_gen = 1'b0;
    carry[0]  = carry_in;
    for (int i = 0; i < CLA_HALF; i++) begin
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built from bit i downward.
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gen_acc  = gen_acc | (gen[j] & prop_acc);
        prop_acc = prop_acc & prop[j];
      end
      carry[i+1] = gen_acc | (prop_acc & carry_in);
      group_gen  = gen_acc;
    end
  end

  assign sum       = prop ^ carry[CLA_HALF-1:0];
  assign carry_out = carry[CLA_HALF];
  assign pg        = &prop;
  assign gg        = group_gen;

endmodule

// File: rtl/cla_subtractor_16bits_pipe.sv
// Two-stage valid/ready subtractor: diff = in0 - in1 - borrow_in (mod 2^WIDTH).
// Define CLA_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module cla_subtractor_16bits_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             borrow_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             out_valid,
`ifdef CLA_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  input  logic             out_ready
);

  localparam int HALF = WIDTH / 2;

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             s2_valid_q, s2_valid_d;
`ifdef CLA_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s1_load;
  logic             s2_load;
  logic [HALF-1:0]  lo_sum;
  logic             lo_carry;
  logic [HALF-1:0]  hi_sum;
  logic             hi_carry;
  logic             lo_pg_unused, lo_gg_unused;
  logic             hi_pg_unused, hi_gg_unused;

  // Subtraction as in0 + ~in1 + !borrow_in; the low half finishes in stage 1.
  cla_adder_8bits u_lo_adder (
    .in0       (in0[HALF-1:0]),
    .in1       (~in1[HALF-1:0]),
    .carry_in  (~borrow_in),
    .sum       (lo_sum),
    .carry_out (lo_carry),
    .pg        (lo_pg_unused),
    .gg        (lo_gg_unused)
  );

  cla_adder_8bits u_hi_adder (
    .in0       (s1_q.a_hi),
    .in1       (s1_q.nb_hi),
    .carry_in  (s1_q.c_half),
    .sum       (hi_sum),
    .carry_out (hi_carry),
    .pg        (hi_pg_unused),
    .gg        (hi_gg_unused)
  );

  // No skid buffer: in_ready is combinational from out_ready through s2_load.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    s2_valid_d = s2_valid_q;
`ifdef CLA_SUB_OVERFLOW_EN
    ovf_d      = ovf_q;
`endif
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.lo     = lo_sum;
        s1_d.c_half = lo_carry;
        s1_d.a_hi   = in0[WIDTH-1:HALF];
        s1_d.nb_hi  = ~in1[WIDTH-1:HALF];
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d   = {hi_sum, s1_q.lo};
        borrow_d = ~hi_carry;
`ifdef CLA_SUB_OVERFLOW_EN
        // Operand signs differ and the result sign departs from the minuend.
        ovf_d = (s1_q.a_hi[HALF-1] != ~s1_q.nb_hi[HALF-1]) &&
                (hi_sum[HALF-1] != s1_q.a_hi[HALF-1]);
`endif
      end
    end
  end

  // NOTE: the datapath registers are reset as well as the valids, because
  // diff/borrow_out (and ovf) must read 0 while in reset, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      s2_valid_q <= 1'b0;
`ifdef CLA_SUB_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // values of the others and advances together.
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      s2_valid_q <= s2_valid_d;
`ifdef CLA_SUB_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign out_valid  = s2_valid_q;
`ifdef CLA_SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_cla_subtractor_16bits_pipe.sv
// Self-checking bench for cla_subtractor_16bits_pipe; directed corner cases plus
// randomized traffic against an arithmetic reference model.
module tb_cla_subtractor_16bits_pipe;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } res_t;

`ifdef CLA_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        borrow_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        out_valid;
  logic        out_ready;
`ifdef CLA_SUB_OVERFLOW_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cla_subtractor_16bits_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0        (in0),
    .in1        (in1),
    .borrow_in  (borrow_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .out_valid  (out_valid),
`ifdef CLA_SUB_OVERFLOW_EN
    .ovf        (ovf),
`endif
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    res_t r;
    int   full;
    int   sres;
    full     = int'(a) - int'(b) - int'(bin);
    sres     = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.diff   = full[15:0];
    r.borrow = (full < 0);
    r.ovf    = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.diff   = diff;
    r.borrow = borrow_out;
`ifdef CLA_SUB_OVERFLOW_EN
    r.ovf    = ovf;
`else
    r.ovf    = 1'b0;
`endif
    return r;
  endfunction

  function automatic bit res_differs(input res_t got, input res_t exp);
    return (got.diff !== exp.diff) || (got.borrow !== exp.borrow) ||
           (OVF_EN && (got.ovf !== exp.ovf));
  endfunction

  // Issue one op into an idle pipe with out_ready=1; lat = cycles to out_valid (-1 on timeout).
  task automatic issue_one(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           output res_t got, output int lat);
    got = '0;
    lat = -1;
    @(negedge clk);
    in0 = a; in1 = b; borrow_in = bin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        got = sample();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in0 = '0; in1 = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || borrow_out !== 1'b0)
      $display("FAIL reset_outputs: out_valid=%b diff=%h borrow=%b, required 0/0000/0",
               out_valid, diff, borrow_out);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    res_t got;
    int   lat;
    issue_one(16'h0005, 16'h0003, 1'b0, got, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL basic_latency: got %0d cycles, required 2", lat);
    else n_pass++;
    n_checks++;
    if (got.diff !== 16'h0002 || got.borrow !== 1'b0)
      $display("FAIL basic_5_minus_3: got %h/%b, required 0002/0", got.diff, got.borrow);
    else n_pass++;
  endtask

  task automatic test_wrap();
    res_t got;
    int   lat;
    issue_one(16'h0000, 16'h0001, 1'b0, got, lat);
    n_checks++;
    if (lat !== 2 || got.diff !== 16'hFFFF || got.borrow !== 1'b1)
      $display("FAIL wrap_0_minus_1: got %h/%b lat %0d, required FFFF/1 lat 2", got.diff, got.borrow, lat);
    else n_pass++;
    issue_one(16'h1234, 16'h1234, 1'b1, got, lat);
    n_checks++;
    if (lat !== 2 || got.diff !== 16'hFFFF || got.borrow !== 1'b1)
      $display("FAIL wrap_equal_bin: got %h/%b lat %0d, required FFFF/1 lat 2", got.diff, got.borrow, lat);
    else n_pass++;
  endtask

  task automatic test_cross_half();
    res_t got;
    int   lat;
    issue_one(16'h0100, 16'h0001, 1'b0, got, lat);
    n_checks++;
    if (lat !== 2 || got.diff !== 16'h00FF || got.borrow !== 1'b0)
      $display("FAIL cross_half: got %h/%b lat %0d, required 00FF/0 lat 2", got.diff, got.borrow, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_v [5];
    logic [15:0] b_v [5];
    logic        c_v [5];
    res_t        got;
    res_t        exp;
    int          idx = 0;
    int          nres = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    bit          acc;
    for (int k = 0; k < 5; k++) begin
      a_v[k] = 16'($urandom);
      b_v[k] = 16'($urandom);
      c_v[k] = 1'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (idx < 5) begin
        in0 = a_v[idx]; in1 = b_v[idx]; borrow_in = c_v[idx]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (idx !== 2 || in_ready !== 1'b0)
      $display("FAIL b2b_stall: accepted %0d in_ready=%b, required 2/0", idx, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && nres < 5; c++) begin
      if (idx < 5) begin
        in0 = a_v[idx]; in1 = b_v[idx]; borrow_in = c_v[idx]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got = sample();
        exp = model(a_v[nres], b_v[nres], c_v[nres]);
        n_checks++;
        if (res_differs(got, exp))
          $display("FAIL b2b_result_%0d: got %h/%b/%b, required %h/%b/%b",
                   nres, got.diff, got.borrow, got.ovf, exp.diff, exp.borrow, exp.ovf);
        else n_pass++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nres++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (nres !== 5 || (last_cyc - first_cyc) !== 4)
      $display("FAIL b2b_drain: got %0d results over %0d cycles, required 5 over 5",
               nres, last_cyc - first_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int accepted = 0;
    int stale = 0;
    bit acc;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 8 && accepted < 2; c++) begin
      if (c > 0) @(negedge clk);
      in0 = 16'($urandom); in1 = 16'($urandom); borrow_in = 1'b0; in_valid = 1'b1;
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (accepted !== 2 || out_valid !== 1'b1)
      $display("FAIL midrst_inflight: accepted %0d out_valid=%b, required 2/1", accepted, out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || borrow_out !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_clear: out_valid=%b diff=%h borrow=%b in_ready=%b, required 0/0000/0/1",
               out_valid, diff, borrow_out, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) $display("FAIL midrst_stale: %0d stale outputs, required 0", stale);
    else n_pass++;
  endtask

`ifdef CLA_SUB_OVERFLOW_EN
  task automatic test_overflow();
    logic [15:0] a_v [3] = '{16'h8000, 16'h7FFF, 16'h0003};
    logic [15:0] b_v [3] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] d_v [3] = '{16'h7FFF, 16'h8000, 16'h0002};
    logic        o_v [3] = '{1'b1, 1'b1, 1'b0};
    res_t        got;
    int          lat;
    for (int k = 0; k < 3; k++) begin
      issue_one(a_v[k], b_v[k], 1'b0, got, lat);
      n_checks++;
      if (lat !== 2 || got.diff !== d_v[k] || got.ovf !== o_v[k])
        $display("FAIL ovf_case_%0d: got %h ovf=%b lat %0d, required %h ovf=%b lat 2",
                 k, got.diff, got.ovf, lat, d_v[k], o_v[k]);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    localparam int N_OPS  = 15000;
    localparam int BUDGET = 60000;
    logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    res_t        q[$];
    res_t        got;
    res_t        exp;
    res_t        held;
    bit          stalled = 1'b0;
    bit          acc;
    int          accepted = 0;
    int          cyc = 0;
    @(negedge clk);
    while ((accepted < N_OPS || q.size() != 0) && cyc < BUDGET) begin
      if (accepted < N_OPS) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in0       = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        in1       = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        borrow_in = 1'($urandom);
      end else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (stalled) begin
        got = sample();
        n_checks++;
        if (out_valid !== 1'b1 || got !== held)
          $display("FAIL rand_stall_hold cycle %0d: got %h/%b valid %b, required held %h/%b valid 1",
                   cyc, got.diff, got.borrow, out_valid, held.diff, held.borrow);
        else n_pass++;
      end
      stalled = out_valid && !out_ready;
      held    = sample();
      if (out_valid && out_ready) begin
        got = sample();
        n_checks++;
        if (q.size() == 0)
          $display("FAIL rand_unexpected cycle %0d: got %h/%b, required no output", cyc, got.diff, got.borrow);
        else begin
          exp = q.pop_front();
          if (res_differs(got, exp))
            $display("FAIL rand_result cycle %0d: got %h/%b/%b, required %h/%b/%b",
                     cyc, got.diff, got.borrow, got.ovf, exp.diff, exp.borrow, exp.ovf);
          else n_pass++;
        end
      end
      @(posedge clk);
      if (acc) begin
        q.push_back(model(in0, in1, borrow_in));
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepted !== N_OPS || q.size() !== 0)
      $display("FAIL rand_complete: accepted %0d pending %0d, required %0d/0", accepted, q.size(), N_OPS);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_cross_half();
    test_back_to_back();
    test_reset_midstream();
`ifdef CLA_SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
